// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM stage bus: pipeline controls and operands in, stall, branch and MEM/WB results out.
interface mem_wb_stage_if;
  logic        branch;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  wbControlExMem;
  logic [31:0] aluResult;
  logic [31:0] aluZero;
  logic [31:0] pc;
  logic [31:0] registerData;
  logic [31:0] writeRegister;
  logic        stall;
  logic        pcSrc;
  logic [31:0] branchTarget;
  logic        regWriteWb;
  logic        memToRegWb;
  logic [31:0] readDataWb;
  logic [31:0] aluResultWb;
  logic [4:0]  writeRegisterWb;
  logic        misalignErr;

  modport master (
    output branch, memRead, memWrite, wbControlExMem, aluResult, aluZero,
           pc, registerData, writeRegister,
    input  stall, pcSrc, branchTarget, regWriteWb, memToRegWb, readDataWb,
           aluResultWb, writeRegisterWb, misalignErr
  );

  modport slave (
    input  branch, memRead, memWrite, wbControlExMem, aluResult, aluZero,
           pc, registerData, writeRegister,
    output stall, pcSrc, branchTarget, regWriteWb, memToRegWb, readDataWb,
           aluResultWb, writeRegisterWb, misalignErr
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage: word RAM access, branch resolve, MEM/WB register; stalls upstream MEM_LATENCY-1 cycles per access.
// Optional MISALIGN_TRAP_EN: unaligned accesses suppress the write, drop regWrite and set sticky misalignErr.
module mem_wb_stage #(
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic          clock,
  input  logic          resetN,
  mem_wb_stage_if.slave bus
);
  localparam int AW    = $clog2(MEM_WORDS);
  localparam int CW    = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam bit MULTI = (MEM_LATENCY > 1);
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_mem [MEM_WORDS];

  logic          w_mem_op;
  logic          w_stall;
  logic          w_done;
  logic          w_mis;
  logic          w_wr_en;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd_data;
  logic          w_unused_bits;

  assign w_mem_op = bus.memRead | bus.memWrite;
  assign w_idx    = bus.aluResult[AW+1:2];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_mem_op && MULTI) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
        else             w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated by resetN so stall drops the instant reset asserts.
  always_comb begin
    w_stall = resetN & (((r_state == IDLE) & w_mem_op & MULTI) |
                        ((r_state == BUSY) & (r_cnt != '0)));
  end

  assign w_done  = resetN & ~w_stall;
  assign w_wr_en = bus.memWrite & ~w_mis;

  always_ff @(posedge clock) begin
    if (w_done && w_wr_en) r_mem[w_idx] <= bus.registerData;
  end

  assign w_rd_data = (bus.memRead & ~bus.memWrite) ? r_mem[w_idx] : '0;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bus.regWriteWb      <= 1'b0;
      bus.memToRegWb      <= 1'b0;
      bus.readDataWb      <= '0;
      bus.aluResultWb     <= '0;
      bus.writeRegisterWb <= '0;
    end else if (w_stall) begin
      bus.regWriteWb      <= 1'b0;
      bus.memToRegWb      <= 1'b0;
      bus.readDataWb      <= '0;
      bus.aluResultWb     <= '0;
      bus.writeRegisterWb <= '0;
    end else begin
      bus.regWriteWb      <= bus.wbControlExMem[1] & ~w_mis;
      bus.memToRegWb      <= bus.wbControlExMem[0];
      bus.readDataWb      <= w_rd_data;
      bus.aluResultWb     <= bus.aluResult;
      bus.writeRegisterWb <= bus.writeRegister[4:0];
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_mis = w_mem_op & (bus.aluResult[1:0] != 2'b00);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)               r_misalign <= 1'b0;
    else if (w_done && w_mis)  r_misalign <= 1'b1;
  end

  assign bus.misalignErr = r_misalign;
`else
  assign w_mis           = 1'b0;
  assign bus.misalignErr = 1'b0;
`endif

  assign bus.stall        = w_stall;
  assign bus.pcSrc        = bus.branch & bus.aluZero[0];
  assign bus.branchTarget = bus.pc;

  assign w_unused_bits = ^{bus.aluZero[31:1], bus.writeRegister[31:5],
                           bus.aluResult[31:AW+2], bus.aluResult[1:0]};
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic resetN;

  logic        br [2], mr [2], mw [2];
  logic [1:0]  wbc [2];
  logic [31:0] alu [2], az [2], pcv [2], rdat [2], wreg [2];

  logic        o_stall [2], o_pcsrc [2], o_rw [2], o_m2r [2], o_mis [2];
  logic [31:0] o_bt [2], o_rd [2], o_alu [2];
  logic [4:0]  o_wr [2];

  int nvec = 0;
  int nmis = 0;

  mem_wb_stage_if bus_a ();
  mem_wb_stage_if bus_b ();

  mem_wb_stage #(.MEM_WORDS(256), .MEM_LATENCY(2)) dut_a (.clock(clock), .resetN(resetN), .bus(bus_a));
  mem_wb_stage #(.MEM_WORDS(256), .MEM_LATENCY(4)) dut_b (.clock(clock), .resetN(resetN), .bus(bus_b));

  assign bus_a.branch = br[0];  assign bus_a.memRead = mr[0];  assign bus_a.memWrite = mw[0];
  assign bus_a.wbControlExMem = wbc[0];  assign bus_a.aluResult = alu[0];  assign bus_a.aluZero = az[0];
  assign bus_a.pc = pcv[0];  assign bus_a.registerData = rdat[0];  assign bus_a.writeRegister = wreg[0];
  assign bus_b.branch = br[1];  assign bus_b.memRead = mr[1];  assign bus_b.memWrite = mw[1];
  assign bus_b.wbControlExMem = wbc[1];  assign bus_b.aluResult = alu[1];  assign bus_b.aluZero = az[1];
  assign bus_b.pc = pcv[1];  assign bus_b.registerData = rdat[1];  assign bus_b.writeRegister = wreg[1];

  assign o_stall[0] = bus_a.stall;  assign o_pcsrc[0] = bus_a.pcSrc;  assign o_bt[0] = bus_a.branchTarget;
  assign o_rw[0] = bus_a.regWriteWb;  assign o_m2r[0] = bus_a.memToRegWb;  assign o_rd[0] = bus_a.readDataWb;
  assign o_alu[0] = bus_a.aluResultWb;  assign o_wr[0] = bus_a.writeRegisterWb;  assign o_mis[0] = bus_a.misalignErr;
  assign o_stall[1] = bus_b.stall;  assign o_pcsrc[1] = bus_b.pcSrc;  assign o_bt[1] = bus_b.branchTarget;
  assign o_rw[1] = bus_b.regWriteWb;  assign o_m2r[1] = bus_b.memToRegWb;  assign o_rd[1] = bus_b.readDataWb;
  assign o_alu[1] = bus_b.aluResultWb;  assign o_wr[1] = bus_b.writeRegisterWb;  assign o_mis[1] = bus_b.misalignErr;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic bit misal(input int d);
`ifdef MISALIGN_TRAP_EN
    return (mr[d] | mw[d]) && (alu[d][1:0] != 2'b00);
`else
    return (d < 0);
`endif
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: RAM image per DUT plus the expected MEM/WB contents; an access completes
  // once it has been presented for MEM_LATENCY-1 stalled cycles.
  logic [31:0] m_mem [2][256];
  bit          m_known [2][256];
  int          age [2];
  bit          e_rw [2], e_m2r [2], e_rdk [2], e_mis [2];
  logic [31:0] e_rd [2], e_alu [2];
  logic [4:0]  e_wr [2];

  always @(posedge clock) begin
    int idx;
    bit op, m;
    for (int d = 0; d < 2; d++) begin
      op  = mr[d] | mw[d];
      idx = int'(alu[d][9:2]);
      m   = misal(d);
      if (!resetN) begin
        age[d] = 0;  e_rw[d] = 0;  e_m2r[d] = 0;  e_rdk[d] = 1;  e_mis[d] = 0;
        e_rd[d] = '0;  e_alu[d] = '0;  e_wr[d] = '0;
      end else if (op && age[d] < lat_of(d) - 1) begin
        age[d]++;
        e_rw[d] = 0;  e_m2r[d] = 0;  e_rdk[d] = 1;  e_rd[d] = '0;  e_alu[d] = '0;  e_wr[d] = '0;
      end else begin
        age[d]   = 0;
        e_rw[d]  = wbc[d][1] & ~m;
        e_m2r[d] = wbc[d][0];
        e_alu[d] = alu[d];
        e_wr[d]  = wreg[d][4:0];
        if (mr[d] && !mw[d]) begin
          e_rd[d] = m_mem[d][idx];  e_rdk[d] = m_known[d][idx];
        end else begin
          e_rd[d] = '0;  e_rdk[d] = 1;
        end
        if (mw[d] && !m) begin
          m_mem[d][idx] = rdat[d];  m_known[d][idx] = 1;
        end
        if (m) e_mis[d] = 1;
      end
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      chk("stall", d, 32'(o_stall[d]), 32'(resetN && (mr[d] | mw[d]) && age[d] < lat_of(d) - 1));
      chk("pcSrc", d, 32'(o_pcsrc[d]), 32'(br[d] & az[d][0]));
      chk("branchTarget", d, o_bt[d], pcv[d]);
      chk("regWriteWb", d, 32'(o_rw[d]), 32'(resetN & e_rw[d]));
      chk("memToRegWb", d, 32'(o_m2r[d]), 32'(resetN & e_m2r[d]));
      chk("aluResultWb", d, o_alu[d], resetN ? e_alu[d] : 32'h0);
      chk("writeRegisterWb", d, 32'(o_wr[d]), resetN ? 32'(e_wr[d]) : 32'h0);
      chk("misalignErr", d, 32'(o_mis[d]), 32'(resetN & e_mis[d]));
      if (!resetN || e_rdk[d]) chk("readDataWb", d, o_rd[d], resetN ? e_rd[d] : 32'h0);
    end
  end

  task automatic nop(input int d);
    br[d] = 0;  mr[d] = 0;  mw[d] = 0;  wbc[d] = 2'b00;  alu[d] = '0;
    az[d] = '0;  pcv[d] = '0;  rdat[d] = '0;  wreg[d] = '0;
  endtask

  // Present one instruction and hold it until the stage stops stalling.
  task automatic issue(input int d, input bit r, input bit w, input logic [1:0] wc,
                       input logic [31:0] a, input logic [31:0] rd, input logic [31:0] wr,
                       output int stalls);
    bit done, s;
    br[d] = 0;  az[d] = '0;  pcv[d] = '0;
    mr[d] = r;  mw[d] = w;  wbc[d] = wc;  alu[d] = a;  rdat[d] = rd;  wreg[d] = wr;
    stalls = 0;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      s = o_stall[d];
      @(posedge clock);
      #1;
      if (s) stalls++;
      else   done = 1;
    end
    if (!done) begin
      nvec++;
      nmis++;
      $display("FAIL issue_timeout dut%0d: got stall stuck high want completion", d);
    end
    nop(d);
  endtask

  initial begin
    int st;
    resetN = 0;
    nop(0);
    nop(1);
    mr[0] = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", 0, 32'(o_stall[0]), 32'h0);
    chk("rst_readData", 0, o_rd[0], 32'h0);
    chk("rst_misalign", 0, 32'(o_mis[0]), 32'h0);
    @(posedge clock);
    #1;
    nop(0);
    resetN = 1;

    issue(0, 0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 0, st);
    chk("st_stalls", 0, st, 1);
    issue(0, 1, 0, 2'b11, 32'h10, 0, 3, st);
    chk("ld_stalls", 0, st, 1);
    chk("ld_readData", 0, o_rd[0], 32'hDEADBEEF);
    chk("ld_regWrite", 0, 32'(o_rw[0]), 1);
    chk("ld_memToReg", 0, 32'(o_m2r[0]), 1);

    issue(0, 0, 0, 2'b10, 32'h1234, 0, 7, st);
    chk("alu_stalls", 0, st, 0);
    chk("alu_aluResult", 0, o_alu[0], 32'h1234);
    chk("alu_writeReg", 0, 32'(o_wr[0]), 7);
    chk("alu_readData", 0, o_rd[0], 0);

    br[0] = 1;  az[0] = 1;  pcv[0] = 32'h40;
    #1;
    chk("br_taken", 0, 32'(o_pcsrc[0]), 1);
    chk("br_target", 0, o_bt[0], 32'h40);
    az[0] = 0;
    #1;
    chk("br_not_taken", 0, 32'(o_pcsrc[0]), 0);
    nop(0);

    issue(0, 1, 1, 2'b11, 32'h20, 32'h99, 4, st);
    chk("rw_readData", 0, o_rd[0], 0);
    issue(0, 1, 0, 2'b11, 32'h20, 0, 4, st);
    chk("rw_stored", 0, o_rd[0], 32'h99);

    issue(0, 0, 1, 2'b10, 32'h13, 32'h77, 5, st);
    chk("mis_stalls", 0, st, 1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_regWrite", 0, 32'(o_rw[0]), 0);
    chk("mis_err", 0, 32'(o_mis[0]), 1);
    issue(0, 1, 0, 2'b11, 32'h10, 0, 6, st);
    chk("mis_ram_kept", 0, o_rd[0], 32'hDEADBEEF);
    chk("mis_sticky", 0, 32'(o_mis[0]), 1);
`else
    chk("mis_regWrite", 0, 32'(o_rw[0]), 1);
    chk("mis_err", 0, 32'(o_mis[0]), 0);
    issue(0, 1, 0, 2'b11, 32'h10, 0, 6, st);
    chk("mis_aligned_word", 0, o_rd[0], 32'h77);
`endif

    issue(1, 0, 1, 2'b00, 32'h400, 32'h5, 0, st);
    chk("l4_st_stalls", 1, st, 3);
    issue(1, 1, 0, 2'b11, 32'h0, 0, 9, st);
    chk("l4_ld_stalls", 1, st, 3);
    chk("l4_wrap_readData", 1, o_rd[1], 32'h5);

    mw[1] = 1;  alu[1] = 32'h400;  rdat[1] = 32'hAAAA;
    @(posedge clock);
    #1;
    resetN = 0;
    #1;
    chk("rst_busy_stall", 1, 32'(o_stall[1]), 0);
    chk("rst_busy_readData", 1, o_rd[1], 0);
    chk("rst_busy_regWrite", 1, 32'(o_rw[1]), 0);
    mw[1] = 0;  mr[1] = 1;  alu[1] = 32'h0;  wbc[1] = 2'b11;
    repeat (2) @(posedge clock);
    #1;
    resetN = 1;
    issue(1, 1, 0, 2'b11, 32'h0, 0, 9, st);
    chk("rst_restart_stalls", 1, st, 3);
    chk("rst_prior_value", 1, o_rd[1], 32'h5);
    chk("rst_misalign_clr", 0, 32'(o_mis[0]), 0);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
